// File: rtl/shift_exec_pipe.sv
// shift_exec_pipe: 2-stage valid/ready SLL/SRL/SRA unit with flush, tag passthrough, zero/illegal flags (clk, rst_n, flush, in_*, out_*); define SHIFT_ROTATE_EN to make op 11 a ROR
module shift_exec_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_illegal
);
  logic             s1_valid, s2_valid, s2_adv, load, ill;
  logic [XLEN-1:0]  s1_a, sll, srl, sra, res;
  logic [4:0]       s1_sh;
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             unused_b;
  assign unused_b  = ^in_b[XLEN-1:5];
  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_adv;
  assign load      = in_valid & in_ready;
  assign out_valid = s2_valid;
  assign sll = s1_a << s1_sh;
  assign srl = s1_a >> s1_sh;
  assign sra = $signed(s1_a) >>> s1_sh;
`ifdef SHIFT_ROTATE_EN
  logic [XLEN-1:0] ror;
  assign ror = srl | (s1_a << (6'd32 - {1'b0, s1_sh}));
  always_comb begin
    res = s1_op == 2'b00 ? sll : s1_op == 2'b01 ? srl : s1_op == 2'b10 ? sra : ror;
    ill = 1'b0;
  end
`else
  always_comb begin
    res = s1_op == 2'b00 ? sll : s1_op == 2'b01 ? srl : s1_op == 2'b10 ? sra : '0;
    ill = &s1_op;
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_a        <= '0;
      s1_sh       <= '0;
      s1_op       <= '0;
      s1_tag      <= '0;
      out_result  <= '0;
      out_tag     <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      s1_valid <= ~flush & (load | (s1_valid & ~s2_adv));
      s2_valid <= ~flush & (s2_adv | (s2_valid & ~out_ready));
      if (load) begin
        s1_a   <= in_a;
        s1_sh  <= in_b[4:0];
        s1_op  <= in_op;
        s1_tag <= in_tag;
      end
      if (s2_adv) begin
        out_result  <= res;
        out_tag     <= s1_tag;
        out_zero    <= res == '0;
        out_illegal <= ill;
      end
    end
  end
endmodule

// File: tb/tb_shift_exec_pipe.sv
// tb_shift_exec_pipe: directed self-checking bench for shift_exec_pipe
module tb_shift_exec_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_zero, out_illegal;
  logic [1:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0, out_result;
  logic [4:0]  in_tag = '0, out_tag;
  int          tests = 0, fails = 0;
  shift_exec_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero),
    .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic offer(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask
  task automatic single(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input logic ill);
    offer(op, a, b, tag);
    step();
    in_valid = 1'b0;
    chk({name, "_lat"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_res"}, out_result, exp);
    chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
    chk({name, "_zero"}, {31'd0, out_zero}, {31'd0, exp == 32'd0});
    chk({name, "_ill"}, {31'd0, out_illegal}, {31'd0, ill});
    step();
    chk({name, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", out_result, 32'd0);
    chk("rst_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_flags", {30'd0, out_zero, out_illegal}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();
    single("sra", 2'b10, 32'h8000_00F0, 32'd4, 5'd7, 32'hF800_000F, 1'b0);
    single("sll31", 2'b00, 32'h0000_0001, 32'h0000_003F, 5'd3, 32'h8000_0000, 1'b0);
    single("srl31", 2'b01, 32'h8000_0000, 32'hFFFF_FFDF, 5'd4, 32'h0000_0001, 1'b0);
    single("sra0", 2'b10, 32'h1234_5678, 32'd0, 5'd5, 32'h1234_5678, 1'b0);
    single("srlz", 2'b01, 32'h0000_000F, 32'd4, 5'd6, 32'h0000_0000, 1'b0);
    single("srafill", 2'b10, 32'h8000_0000, 32'd31, 5'd8, 32'hFFFF_FFFF, 1'b0);
`ifdef SHIFT_ROTATE_EN
    single("ror", 2'b11, 32'h0000_00FF, 32'd8, 5'd9, 32'hFF00_0000, 1'b0);
    single("ror0", 2'b11, 32'hDEAD_BEEF, 32'd0, 5'd9, 32'hDEAD_BEEF, 1'b0);
`else
    single("rsv", 2'b11, 32'h0000_00FF, 32'd8, 5'd9, 32'h0000_0000, 1'b1);
`endif
    for (int i = 1; i <= 4; i++) begin
      offer(2'b00, 32'd1, 32'(i), 5'(i));
      chk("strm_ready", {31'd0, in_ready}, 32'd1);
      step();
      if (i >= 2) begin
        chk("strm_valid", {31'd0, out_valid}, 32'd1);
        chk("strm_tag", {27'd0, out_tag}, 32'(i - 1));
        chk("strm_res", out_result, 32'd1 << (i - 1));
      end
    end
    in_valid = 1'b0;
    step();
    chk("strm_valid4", {31'd0, out_valid}, 32'd1);
    chk("strm_tag4", {27'd0, out_tag}, 32'd4);
    step();
    chk("strm_end", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    offer(2'b00, 32'd3, 32'd1, 5'd10);
    step();
    offer(2'b01, 32'd5, 32'd1, 5'd11);
    step();
    offer(2'b10, 32'hFFFF_FFF0, 32'd2, 5'd12);
    for (int k = 0; k < 3; k++) begin
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_tag", {27'd0, out_tag}, 32'd10);
      chk("bp_res", out_result, 32'd6);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_tag_b", {27'd0, out_tag}, 32'd11);
    chk("bp_res_b", out_result, 32'd2);
    step();
    chk("bp_tag_c", {27'd0, out_tag}, 32'd12);
    chk("bp_res_c", out_result, 32'hFFFF_FFFC);
    chk("bp_valid_c", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_end", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    offer(2'b00, 32'd1, 32'd2, 5'd20);
    step();
    offer(2'b00, 32'd1, 32'd3, 5'd21);
    step();
    chk("fl_pre", {31'd0, out_valid}, 32'd1);
    offer(2'b00, 32'd1, 32'd4, 5'd22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_stale", {31'd0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;
    offer(2'b00, 32'd1, 32'd1, 5'd25);
    step();
    in_valid = 1'b0;
    step();
    chk("mr_pre", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_res", out_result, 32'd0);
    chk("mr_tag", {27'd0, out_tag}, 32'd0);
    step();
    chk("mr_after", {31'd0, out_valid}, 32'd0);
    single("post", 2'b00, 32'h0000_00FF, 32'd4, 5'd31, 32'h0000_0FF0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_exec_pipe.md
Name: shift_exec_pipe

Overview:
- Two-stage pipelined shift execute unit for the RV32I datapath; performs SLL/SRL/SRA on 32-bit operands.
- Sits between the decode/issue stage and writeback. The SRA path uses the existing combinational arithmetic barrel shifter; SLL/SRL use sibling combinational shifters.
- Has valid/ready handshakes on both sides, full throughput (1 op/cycle), 2-cycle latency, a flush input, and a register-destination tag carried through.

Parameters:
- XLEN, 32, operand/result width (only 32 supported; shamt width fixed at 5)
- TAG_W, 5, width of passthrough destination tag (rd index)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- flush  input  1  synchronous kill of all in-flight ops
- in_valid  input  1  upstream op present
- in_ready  output  1  unit can accept op this cycle
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (ROR when feature enabled)
- in_a  input  XLEN  value to shift (rs1)
- in_b  input  XLEN  shift source; only in_b[4:0] used
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_result  output  XLEN  shifted value
- out_tag  output  TAG_W  tag of result
- out_zero  output  1  out_result == 0
- out_illegal  output  1  op was reserved/unsupported

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset (rst_n=0 at posedge): s1_valid=0, s2_valid=0, out_result=0, out_tag=0, out_zero=0, out_illegal=0. All data registers are cleared. in_ready=1 in the first cycle after reset.
- Stage 1 (S1) registers in_a, in_b[4:0] as shamt, in_op and in_tag; the upper bits of in_b are ignored.
- Stage 2 (S2) computes the shift from the S1 registers and registers the result, tag, zero flag and illegal flag. The outputs are driven directly from the S2 registers.
- Advance rules:
  - s2_adv = s1_valid & (~s2_valid | out_ready)
  - in_ready = ~s1_valid | s2_adv (combinational from out_ready; no other comb paths in→out)
  - S1 loads when in_valid & in_ready; s1_valid next = (in_valid & in_ready) | (s1_valid & ~s2_adv).
  - S2 loads when s2_adv; s2_valid next = s2_adv | (s2_valid & ~out_ready).
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+1 when there is no backpressure. Back-to-back ops sustain 1/cycle.
- Backpressure: while out_valid=1 and out_ready=0, the S2 contents are held stable. S1 holds its op; in_ready=0 once S1 is also full. No op is dropped or duplicated.
- Arithmetic:
  - SLL: a << shamt
  - SRL: a >> shamt, zero fill
  - SRA: a >> shamt, fill with a[31]
  - shamt=0 yields a unchanged for all ops.
- Reserved op 11 (feature disabled): result=0, out_illegal=1. The op still flows and is handshaken normally.
- flush=1 at posedge clears s1_valid and s2_valid. Data registers may keep stale values. Any in_valid in that cycle is discarded. flush has priority over load and advance. in_ready is unaffected by flush in the same cycle.
- rst_n has priority over flush.
- Reset mid-operation: all in-flight ops are lost. No out_valid appears until new ops are accepted.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: op 11 = ROR, giving (a >> shamt) | (a << (32 - shamt)); shamt=0 yields a. out_illegal is 0 for all ops.
- Undefined: op 11 behaves as reserved (result 0, out_illegal=1). No rotate logic is synthesized.

Test Plan:
- SRA: a=0x8000_00F0, b=4, out_ready=1 → 2 cycles later out_result=0xF800_000F, out_zero=0, tag preserved.
- Ops with upper-bit masking: SLL a=0x0000_0001, b=0x0000_003F (shamt 31) → 0x8000_0000. SRL a=0x8000_0000, b=31 → 0x0000_0001. SRA a=0x1234_5678, b=0 → 0x1234_5678.
- Streaming: 4 back-to-back ops with tags 1..4 and out_ready=1 → out_valid high for 4 consecutive cycles, tags in order 1..4, in_ready stays 1.
- Backpressure:
  - Hold out_ready=0 with 3 ops offered → after 2 accepts in_ready=0, and out_result/out_tag remain stable.
  - Release out_ready → all 3 results emerge in order with no loss.
- Flush with two ops in flight (S1 and S2 full): flush=1 for one cycle → out_valid=0 the next cycle, and no stale result appears afterward.
- Reserved op 11, a=0x0000_00FF, b=8:
  - without SHIFT_ROTATE_EN → result 0, out_illegal=1.
  - with SHIFT_ROTATE_EN → result 0xFF00_0000, out_illegal=0.
